decoder_pipe_riscv: RTL and testbench

Registered, parametrised decode stage for the RISC-V core. It accepts fetched instructions over a valid/ready handshake and decodes them through a combinational core. Optional M-extension and CSR/system decode are selected by parameter. Results are held in a 2-entry skid buffer, so the stage runs at full throughput and absorbs downstream and LSU stalls without a combinational ready path. It sits between fetch and execute, and replaces the purely combinational decoder.

---
 rtl/riscv_pkg.sv | 115 +++++++++++
 rtl/decoder_pipe_riscv_if.sv | 58 +++++
 rtl/decode_core_riscv.sv | 127 ++++++++++++
 rtl/decoder_pipe_riscv.sv | 135 +++++++++++++
 tb/tb_decoder_pipe_riscv.sv | 301 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/riscv_pkg.sv
// Shared decode types for the RISC-V core.
// Opcodes, ALU/operand codes and the per-entry decode bundle.
package riscv_pkg;

  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

  localparam logic [6:0] F7_BASE   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  localparam logic [31:0] INSTR_ECALL = 32'h0000_0073;
  localparam logic [31:0] INSTR_MRET  = 32'h3020_0073;

  localparam logic [4:0] ALU_ADD  = 5'd0;
  localparam logic [4:0] ALU_SUB  = 5'd1;
  localparam logic [4:0] ALU_XOR  = 5'd2;
  localparam logic [4:0] ALU_OR   = 5'd3;
  localparam logic [4:0] ALU_AND  = 5'd4;
  localparam logic [4:0] ALU_SLL  = 5'd5;
  localparam logic [4:0] ALU_SRL  = 5'd6;
  localparam logic [4:0] ALU_SRA  = 5'd7;
  localparam logic [4:0] ALU_SLT  = 5'd8;
  localparam logic [4:0] ALU_SLTU = 5'd9;
  localparam logic [4:0] ALU_EQ   = 5'd10;
  localparam logic [4:0] ALU_NE   = 5'd11;
  localparam logic [4:0] ALU_LT   = 5'd12;
  localparam logic [4:0] ALU_GE   = 5'd13;
  localparam logic [4:0] ALU_LTU  = 5'd14;
  localparam logic [4:0] ALU_GEU  = 5'd15;

  localparam logic [1:0] OP_A_RS1  = 2'd0;
  localparam logic [1:0] OP_A_PC   = 2'd1;
  localparam logic [1:0] OP_A_ZERO = 2'd2;
  localparam logic [1:0] OP_A_ZIMM = 2'd3;

  localparam logic [2:0] OP_B_RS2   = 3'd0;
  localparam logic [2:0] OP_B_IMM_I = 3'd1;
  localparam logic [2:0] OP_B_IMM_S = 3'd2;
  localparam logic [2:0] OP_B_IMM_U = 3'd3;
  localparam logic [2:0] OP_B_FOUR  = 3'd4;

  localparam logic [2:0] LDST_B  = 3'b000;
  localparam logic [2:0] LDST_H  = 3'b001;
  localparam logic [2:0] LDST_W  = 3'b010;
  localparam logic [2:0] LDST_BU = 3'b100;
  localparam logic [2:0] LDST_HU = 3'b101;

  typedef enum logic [1:0] {
    WB_EX, WB_LSU, WB_CSR, WB_MDU
  } wb_src_e;

  typedef enum logic [1:0] {
    BUF_EMPTY, BUF_ONE, BUF_TWO
  } buf_state_e;

  typedef struct packed {
    logic [1:0] op_a_sel;
    logic [2:0] op_b_sel;
    logic [4:0] alu_op;
    logic       mdu_req;
    logic [2:0] mdu_op;
    logic       mem_req;
    logic       mem_we;
    logic [2:0] mem_size;
    logic       gpr_we;
    wb_src_e    wb_src;
    logic [2:0] csr_op;
    logic       csr_we;
    logic       illegal;
    logic       branch;
    logic       jal;
    logic       jalr;
    logic       ecall;
    logic       mret;
  } dec_ctrl_t;

  function automatic logic [4:0] op_alu(logic [2:0] f3, logic alt);
    logic [4:0] r;
    unique case (f3)
      3'b000:  r = alt ? ALU_SUB : ALU_ADD;
      3'b001:  r = ALU_SLL;
      3'b010:  r = ALU_SLT;
      3'b011:  r = ALU_SLTU;
      3'b100:  r = ALU_XOR;
      3'b101:  r = alt ? ALU_SRA : ALU_SRL;
      3'b110:  r = ALU_OR;
      default: r = ALU_AND;
    endcase
    return r;
  endfunction

  function automatic logic [4:0] br_alu(logic [2:0] f3);
    logic [4:0] r;
    unique case (f3)
      3'b001:  r = ALU_NE;
      3'b100:  r = ALU_LT;
      3'b101:  r = ALU_GE;
      3'b110:  r = ALU_LTU;
      3'b111:  r = ALU_GEU;
      default: r = ALU_EQ;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/decoder_pipe_riscv_if.sv
// Fetch-side and execute-side signals of the decode stage.
// slave is the stage itself, master is its environment.
interface decoder_pipe_riscv_if #(
  parameter int PC_W = 32
);
  logic [31:0]     instr_i;
  logic [PC_W-1:0] pc_i;
  logic            instr_valid_i;
  logic            instr_ready_o;
  logic            flush_i;
  logic            dec_ready_i;
  logic            lsu_stall_req_i;
  logic            dec_valid_o;
  logic [PC_W-1:0] dec_pc_o;
  logic [31:0]     dec_instr_o;
  logic [1:0]      ex_op_a_sel_o;
  logic [2:0]      ex_op_b_sel_o;
  logic [4:0]      alu_op_o;
  logic            mdu_req_o;
  logic [2:0]      mdu_op_o;
  logic            mem_req_o;
  logic            mem_we_o;
  logic [2:0]      mem_size_o;
  logic            gpr_we_a_o;
  logic [1:0]      wb_src_sel_o;
  logic [2:0]      csr_op_o;
  logic            csr_we_o;
  logic            illegal_instr_o;
  logic            branch_o;
  logic            jal_o;
  logic            jalr_o;
  logic            ecall_o;
  logic            mret_o;

  modport slave (
    input  instr_i, pc_i, instr_valid_i, flush_i,
    input  dec_ready_i, lsu_stall_req_i,
    output instr_ready_o, dec_valid_o, dec_pc_o,
    output dec_instr_o, ex_op_a_sel_o, ex_op_b_sel_o,
    output alu_op_o, mdu_req_o, mdu_op_o, mem_req_o,
    output mem_we_o, mem_size_o, gpr_we_a_o,
    output wb_src_sel_o, csr_op_o, csr_we_o,
    output illegal_instr_o, branch_o, jal_o, jalr_o,
    output ecall_o, mret_o
  );

  modport master (
    output instr_i, pc_i, instr_valid_i, flush_i,
    output dec_ready_i, lsu_stall_req_i,
    input  instr_ready_o, dec_valid_o, dec_pc_o,
    input  dec_instr_o, ex_op_a_sel_o, ex_op_b_sel_o,
    input  alu_op_o, mdu_req_o, mdu_op_o, mem_req_o,
    input  mem_we_o, mem_size_o, gpr_we_a_o,
    input  wb_src_sel_o, csr_op_o, csr_we_o,
    input  illegal_instr_o, branch_o, jal_o, jalr_o,
    input  ecall_o, mret_o
  );
endinterface

// File: rtl/decode_core_riscv.sv
// Combinational RV32I decoder with optional M and CSR/system.
// An illegal word yields an all-zero bundle with only illegal set.
module decode_core_riscv
  import riscv_pkg::*;
#(
  parameter bit M_EXT_EN = 1'b1,
  parameter bit CSR_EN   = 1'b1
) (
  input  logic [31:0] instr,
  output dec_ctrl_t   ctrl
);

  logic [6:0] opc;
  logic [2:0] f3;
  logic [6:0] f7;
  logic       bad;
  dec_ctrl_t  d;

  assign opc = instr[6:0];
  assign f3  = instr[14:12];
  assign f7  = instr[31:25];

  // decode by opcode, then blank the bundle for illegal words
  always_comb begin
    d   = '0;
    bad = 1'b0;
    unique case (1'b1)
      (opc == OPC_LUI): begin
        d.op_a_sel = OP_A_ZERO;
        d.op_b_sel = OP_B_IMM_U;
        d.gpr_we   = 1'b1;
      end
      (opc == OPC_AUIPC): begin
        d.op_a_sel = OP_A_PC;
        d.op_b_sel = OP_B_IMM_U;
        d.gpr_we   = 1'b1;
      end
      (opc == OPC_JAL): begin
        d.op_a_sel = OP_A_PC;
        d.op_b_sel = OP_B_FOUR;
        d.gpr_we   = 1'b1;
        d.jal      = 1'b1;
      end
      (opc == OPC_JALR): begin
        bad        = f3 != 3'b000;
        d.op_a_sel = OP_A_PC;
        d.op_b_sel = OP_B_FOUR;
        d.gpr_we   = 1'b1;
        d.jalr     = 1'b1;
      end
      (opc == OPC_BRANCH): begin
        bad        = f3[2:1] == 2'b01;
        d.op_a_sel = OP_A_RS1;
        d.op_b_sel = OP_B_RS2;
        d.alu_op   = br_alu(f3);
        d.branch   = 1'b1;
      end
      (opc == OPC_LOAD): begin
        bad        = !(f3 inside {LDST_B, LDST_H, LDST_W,
                                  LDST_BU, LDST_HU});
        d.op_a_sel = OP_A_RS1;
        d.op_b_sel = OP_B_IMM_I;
        d.mem_req  = 1'b1;
        d.mem_size = f3;
        d.gpr_we   = 1'b1;
        d.wb_src   = WB_LSU;
      end
      (opc == OPC_STORE): begin
        bad        = !(f3 inside {LDST_B, LDST_H, LDST_W});
        d.op_b_sel = OP_B_IMM_S;
        d.mem_req  = 1'b1;
        d.mem_we   = 1'b1;
        d.mem_size = f3;
      end
      (opc == OPC_OP_IMM): begin
        d.op_b_sel = OP_B_IMM_I;
        d.gpr_we   = 1'b1;
        d.alu_op   = op_alu(f3, (f3 == 3'b101) && (f7 == F7_ALT));
        if (f3 == 3'b001)
          bad = f7 != F7_BASE;
        if (f3 == 3'b101)
          bad = (f7 != F7_BASE) && (f7 != F7_ALT);
      end
      (opc == OPC_OP): begin
        d.op_b_sel = OP_B_RS2;
        d.gpr_we   = 1'b1;
        if (f7 == F7_MULDIV) begin
          bad       = !M_EXT_EN;
          d.mdu_req = 1'b1;
          d.mdu_op  = f3;
          d.wb_src  = WB_MDU;
        end else begin
          bad      = !((f7 == F7_BASE) ||
                       ((f7 == F7_ALT) &&
                        ((f3 == 3'b000) || (f3 == 3'b101))));
          d.alu_op = op_alu(f3, f7 == F7_ALT);
        end
      end
      (opc == OPC_MISC_MEM): begin
        d.op_a_sel = OP_A_RS1;
      end
      (opc == OPC_SYSTEM): begin
        if (!CSR_EN || (f3 == 3'b100)) begin
          bad = 1'b1;
        end else if (f3 == 3'b000) begin
          d.ecall = instr == INSTR_ECALL;
          d.mret  = instr == INSTR_MRET;
          bad     = !(d.ecall || d.mret);
        end else begin
          d.csr_we   = 1'b1;
          d.csr_op   = f3;
          d.gpr_we   = 1'b1;
          d.wb_src   = WB_CSR;
          d.op_a_sel = f3[2] ? OP_A_ZIMM : OP_A_RS1;
        end
      end
      default: bad = 1'b1;
    endcase
    if (bad) begin
      d         = '0;
      d.illegal = 1'b1;
    end
  end

  assign ctrl = d;

endmodule

// File: rtl/decoder_pipe_riscv.sv
// Registered decode stage: decode core feeding a 2-entry skid buffer.
// Ready is registered, so no combinational path from dec_ready_i.
module decoder_pipe_riscv
  import riscv_pkg::*;
#(
  parameter bit M_EXT_EN = 1'b1,
  parameter bit CSR_EN   = 1'b1,
  parameter int PC_W     = 32
) (
  input logic           clk_i,
  input logic           rst_i,
  decoder_pipe_riscv_if.slave bus
);

  buf_state_e      state_q, state_d;
  logic            ready_q;
  logic            valid, accept, consume;
  logic            load_head, load_skid, promote;
  dec_ctrl_t       new_ctrl, head_ctrl_q, skid_ctrl_q, out_ctrl;
  logic [PC_W-1:0] head_pc_q, skid_pc_q;
  logic [31:0]     head_instr_q, skid_instr_q;

  decode_core_riscv #(
    .M_EXT_EN (M_EXT_EN),
    .CSR_EN   (CSR_EN)
  ) u_core (
    .instr (bus.instr_i),
    .ctrl  (new_ctrl)
  );

  assign valid   = state_q != BUF_EMPTY;
  assign accept  = bus.instr_valid_i & ready_q & ~bus.flush_i;
  assign consume = valid & bus.dec_ready_i & ~bus.lsu_stall_req_i;

  // occupancy state and registered ready
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= BUF_EMPTY;
      ready_q <= 1'b1;
    end else begin
      state_q <= state_d;
      ready_q <= state_d != BUF_TWO;
    end
  end

  // next occupancy and entry load strobes; flush wins
  always_comb begin
    state_d   = state_q;
    load_head = 1'b0;
    load_skid = 1'b0;
    promote   = 1'b0;
    if (bus.flush_i) begin
      state_d = BUF_EMPTY;
    end else begin
      unique case (state_q)
        BUF_EMPTY: begin
          if (accept) begin
            state_d   = BUF_ONE;
            load_head = 1'b1;
          end
        end
        BUF_ONE: begin
          if (accept && consume) begin
            load_head = 1'b1;
          end else if (accept) begin
            state_d   = BUF_TWO;
            load_skid = 1'b1;
          end else if (consume) begin
            state_d = BUF_EMPTY;
          end
        end
        BUF_TWO: begin
          if (consume) begin
            state_d = BUF_ONE;
            promote = 1'b1;
          end
        end
        default: state_d = BUF_EMPTY;
      endcase
    end
  end

  // head and skid entries hold decoded results, never re-decoded
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      head_ctrl_q  <= '0;
      head_pc_q    <= '0;
      head_instr_q <= '0;
      skid_ctrl_q  <= '0;
      skid_pc_q    <= '0;
      skid_instr_q <= '0;
    end else begin
      if (load_head) begin
        head_ctrl_q  <= new_ctrl;
        head_pc_q    <= bus.pc_i;
        head_instr_q <= bus.instr_i;
      end else if (promote) begin
        head_ctrl_q  <= skid_ctrl_q;
        head_pc_q    <= skid_pc_q;
        head_instr_q <= skid_instr_q;
      end
      if (load_skid) begin
        skid_ctrl_q  <= new_ctrl;
        skid_pc_q    <= bus.pc_i;
        skid_instr_q <= bus.instr_i;
      end
    end
  end

  assign out_ctrl = valid ? head_ctrl_q : '0;

  assign bus.instr_ready_o   = ready_q;
  assign bus.dec_valid_o     = valid;
  assign bus.dec_pc_o        = valid ? head_pc_q : '0;
  assign bus.dec_instr_o     = valid ? head_instr_q : '0;
  assign bus.ex_op_a_sel_o   = out_ctrl.op_a_sel;
  assign bus.ex_op_b_sel_o   = out_ctrl.op_b_sel;
  assign bus.alu_op_o        = out_ctrl.alu_op;
  assign bus.mdu_req_o       = out_ctrl.mdu_req;
  assign bus.mdu_op_o        = out_ctrl.mdu_op;
  assign bus.mem_req_o       = out_ctrl.mem_req;
  assign bus.mem_we_o        = out_ctrl.mem_we;
  assign bus.mem_size_o      = out_ctrl.mem_size;
  assign bus.gpr_we_a_o      = out_ctrl.gpr_we;
  assign bus.wb_src_sel_o    = out_ctrl.wb_src;
  assign bus.csr_op_o        = out_ctrl.csr_op;
  assign bus.csr_we_o        = out_ctrl.csr_we;
  assign bus.illegal_instr_o = out_ctrl.illegal;
  assign bus.branch_o        = out_ctrl.branch;
  assign bus.jal_o           = out_ctrl.jal;
  assign bus.jalr_o          = out_ctrl.jalr;
  assign bus.ecall_o         = out_ctrl.ecall;
  assign bus.mret_o          = out_ctrl.mret;

endmodule

// File: tb/tb_decoder_pipe_riscv.sv
// Bench for decoder_pipe_riscv: full-feature and M/CSR-less instances.
// Queue-based buffer model plus a table-driven reference decoder.
module tb_decoder_pipe_riscv;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] instr, pc;
  logic        vld, flush, drdy, stall;
  logic        dummy;
  int          errs = 0;
  int          checks = 0;
  logic [63:0] q[$];

  always #5 clk = ~clk;

  decoder_pipe_riscv_if #(.PC_W(32)) bus_a ();
  decoder_pipe_riscv_if #(.PC_W(32)) bus_b ();

  assign bus_a.instr_i         = instr;
  assign bus_a.pc_i            = pc;
  assign bus_a.instr_valid_i   = vld;
  assign bus_a.flush_i         = flush;
  assign bus_a.dec_ready_i     = drdy;
  assign bus_a.lsu_stall_req_i = stall;
  assign bus_b.instr_i         = instr;
  assign bus_b.pc_i            = pc;
  assign bus_b.instr_valid_i   = vld;
  assign bus_b.flush_i         = flush;
  assign bus_b.dec_ready_i     = drdy;
  assign bus_b.lsu_stall_req_i = stall;

  decoder_pipe_riscv #(
    .M_EXT_EN (1'b1),
    .CSR_EN   (1'b1),
    .PC_W     (32)
  ) dut_a (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus_a)
  );

  decoder_pipe_riscv #(
    .M_EXT_EN (1'b0),
    .CSR_EN   (1'b0),
    .PC_W     (32)
  ) dut_b (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus_b)
  );

  logic [31:0] ctl_a, ctl_b;
  assign ctl_a = {bus_a.ex_op_a_sel_o, bus_a.ex_op_b_sel_o,
                  bus_a.alu_op_o, bus_a.mdu_req_o, bus_a.mdu_op_o,
                  bus_a.mem_req_o, bus_a.mem_we_o, bus_a.mem_size_o,
                  bus_a.gpr_we_a_o, bus_a.wb_src_sel_o,
                  bus_a.csr_op_o, bus_a.csr_we_o,
                  bus_a.illegal_instr_o, bus_a.branch_o,
                  bus_a.jal_o, bus_a.jalr_o, bus_a.ecall_o,
                  bus_a.mret_o};
  assign ctl_b = {bus_b.ex_op_a_sel_o, bus_b.ex_op_b_sel_o,
                  bus_b.alu_op_o, bus_b.mdu_req_o, bus_b.mdu_op_o,
                  bus_b.mem_req_o, bus_b.mem_we_o, bus_b.mem_size_o,
                  bus_b.gpr_we_a_o, bus_b.wb_src_sel_o,
                  bus_b.csr_op_o, bus_b.csr_we_o,
                  bus_b.illegal_instr_o, bus_b.branch_o,
                  bus_b.jal_o, bus_b.jalr_o, bus_b.ecall_o,
                  bus_b.mret_o};

  localparam logic [4:0] OP_TAB [8] = '{5'd0, 5'd5, 5'd8, 5'd9,
                                        5'd2, 5'd6, 5'd3, 5'd4};
  localparam logic [4:0] BR_TAB [8] = '{5'd10, 5'd11, 5'd0, 5'd0,
                                        5'd12, 5'd13, 5'd14, 5'd15};
  localparam logic [6:0] OPCS [11] = '{7'h37, 7'h17, 7'h6f, 7'h67,
                                       7'h63, 7'h03, 7'h23, 7'h13,
                                       7'h33, 7'h0f, 7'h73};

  task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_dec(logic [31:0] w, bit m_en,
                                          bit c_en);
    logic [6:0] opc, f7;
    logic [2:0] f3, b, mop, sz, cop;
    logic [1:0] a, wb;
    logic [4:0] alu;
    logic md, mr, mw, we, cwe, br, jl, jr, ec, mt, bad;
    opc = w[6:0]; f3 = w[14:12]; f7 = w[31:25];
    a = 2'd0; b = 3'd0; alu = 5'd0; md = 1'b0; mop = 3'd0;
    mr = 1'b0; mw = 1'b0; sz = 3'd0; we = 1'b0; wb = 2'd0;
    cop = 3'd0; cwe = 1'b0; br = 1'b0; jl = 1'b0; jr = 1'b0;
    ec = 1'b0; mt = 1'b0; bad = 1'b0;
    case (opc)
      7'h37: begin a = 2'd2; b = 3'd3; we = 1'b1; end
      7'h17: begin a = 2'd1; b = 3'd3; we = 1'b1; end
      7'h6f: begin a = 2'd1; b = 3'd4; we = 1'b1; jl = 1'b1; end
      7'h67: begin
        bad = f3 != 3'd0; a = 2'd1; b = 3'd4; we = 1'b1; jr = 1'b1;
      end
      7'h63: begin
        bad = (f3 == 3'd2) || (f3 == 3'd3); alu = BR_TAB[f3]; br = 1'b1;
      end
      7'h03: begin
        bad = !(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        b = 3'd1; mr = 1'b1; sz = f3; we = 1'b1; wb = 2'd1;
      end
      7'h23: begin
        bad = f3 > 3'd2; b = 3'd2; mr = 1'b1; mw = 1'b1; sz = f3;
      end
      7'h13: begin
        b = 3'd1; we = 1'b1; alu = OP_TAB[f3];
        if (f3 == 3'd1) bad = f7 != 7'h00;
        if (f3 == 3'd5) begin
          bad = !((f7 == 7'h00) || (f7 == 7'h20));
          if (f7 == 7'h20) alu = 5'd7;
        end
      end
      7'h33: begin
        we = 1'b1;
        if (f7 == 7'h01) begin
          bad = !m_en; md = 1'b1; mop = f3; wb = 2'd3;
        end else if (f7 == 7'h00) alu = OP_TAB[f3];
        else if (f7 == 7'h20 && f3 == 3'd0) alu = 5'd1;
        else if (f7 == 7'h20 && f3 == 3'd5) alu = 5'd7;
        else bad = 1'b1;
      end
      7'h0f: bad = 1'b0;
      7'h73: begin
        if (!c_en || f3 == 3'd4) bad = 1'b1;
        else if (f3 == 3'd0) begin
          ec = w == 32'h0000_0073;
          mt = w == 32'h3020_0073;
          bad = !(ec || mt);
        end else begin
          cwe = 1'b1; cop = f3; we = 1'b1; wb = 2'd2;
          a = f3[2] ? 2'd3 : 2'd0;
        end
      end
      default: bad = 1'b1;
    endcase
    if (bad) return 32'h0000_0020;
    return {a, b, alu, md, mop, mr, mw, sz, we, wb, cop, cwe,
            1'b0, br, jl, jr, ec, mt};
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [31:0] w;
    int k;
    w = $urandom();
    k = $urandom_range(0, 13);
    if (k < 11) w[6:0] = OPCS[k];
    case ($urandom_range(0, 5))
      0: w[31:25] = 7'h00;
      1: w[31:25] = 7'h20;
      2: w[31:25] = 7'h01;
      default: ;
    endcase
    if ($urandom_range(0, 9) == 0)
      w = ($urandom_range(0, 1) == 1) ? 32'h0000_0073 : 32'h3020_0073;
    return w;
  endfunction

  task automatic compare();
    check("valid_a", bus_a.dec_valid_o, q.size() != 0);
    check("ready_a", bus_a.instr_ready_o, q.size() < 2);
    check("valid_b", bus_b.dec_valid_o, q.size() != 0);
    check("ready_b", bus_b.instr_ready_o, q.size() < 2);
    if (q.size() != 0) begin
      check("pc", bus_a.dec_pc_o, q[0][63:32]);
      check("instr", bus_a.dec_instr_o, q[0][31:0]);
      check("ctl_a", ctl_a, ref_dec(q[0][31:0], 1'b1, 1'b1));
      check("ctl_b", ctl_b, ref_dec(q[0][31:0], 1'b0, 1'b0));
    end else begin
      check("pc_idle", bus_a.dec_pc_o, 0);
      check("ctl_a_idle", ctl_a, 0);
      check("ctl_b_idle", ctl_b, 0);
    end
  endtask

  task automatic step(input logic v, input logic [31:0] w,
                      input logic [31:0] p, input logic fl,
                      input logic dr, input logic st,
                      output logic acc);
    logic con;
    compare();
    vld = v; instr = w; pc = p; flush = fl; drdy = dr; stall = st;
    acc = v && (q.size() < 2) && !fl;
    con = (q.size() != 0) && dr && !st;
    @(posedge clk);
    if (fl) q.delete();
    else begin
      if (con) void'(q.pop_front());
      if (acc) q.push_back({p, w});
    end
    #1;
  endtask

  task automatic drain();
    for (int i = 0; i < 3; i++)
      step(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0, dummy);
  endtask

  initial begin
    logic [31:0] ws [4];
    logic [31:0] got[$];
    int idx, first_c, last_c;
    logic a;
    rst = 1'b1; vld = 1'b0; instr = '0; pc = '0;
    flush = 1'b0; drdy = 1'b0; stall = 1'b0;
    #12;
    compare();
    rst = 1'b0;
    @(posedge clk); #1;

    step(1'b1, 32'h003100B3, 32'h100, 1'b0, 1'b1, 1'b0, dummy);
    check("add_valid", bus_a.dec_valid_o, 1);
    check("add_alu", bus_a.alu_op_o, 0);
    check("add_we", bus_a.gpr_we_a_o, 1);
    check("add_wb", bus_a.wb_src_sel_o, 0);
    check("add_ill", bus_a.illegal_instr_o, 0);
    step(1'b1, 32'h023100B3, 32'h104, 1'b0, 1'b1, 1'b0, dummy);
    check("mul_req", bus_a.mdu_req_o, 1);
    check("mul_op", bus_a.mdu_op_o, 0);
    check("mul_wb", bus_a.wb_src_sel_o, 3);
    check("mul_noM_ill", bus_b.illegal_instr_o, 1);
    check("mul_noM_we", bus_b.gpr_we_a_o, 0);
    step(1'b1, 32'h300110F3, 32'h108, 1'b0, 1'b1, 1'b0, dummy);
    check("csr_we", bus_a.csr_we_o, 1);
    check("csr_op", bus_a.csr_op_o, 1);
    check("csr_wb", bus_a.wb_src_sel_o, 2);
    step(1'b1, 32'h00000073, 32'h10c, 1'b0, 1'b1, 1'b0, dummy);
    check("ecall", bus_a.ecall_o, 1);
    step(1'b1, 32'h30200073, 32'h110, 1'b0, 1'b1, 1'b0, dummy);
    check("mret", bus_a.mret_o, 1);
    step(1'b1, 32'h00100073, 32'h114, 1'b0, 1'b1, 1'b0, dummy);
    check("ebreak_ill", bus_a.illegal_instr_o, 1);
    drain();

    ws[0] = 32'h003100B3; ws[1] = 32'h00500113;
    ws[2] = 32'h0000A183; ws[3] = 32'h00208663;
    idx = 0; first_c = -1; last_c = -1;
    for (int c = 0; c < 16 && got.size() < 4; c++) begin
      if (c == 2) check("stall_ready", bus_a.instr_ready_o, 0);
      if (c == 2 || c == 3)
        check("stall_head", bus_a.dec_instr_o, ws[0]);
      if (bus_a.dec_valid_o && c >= 3) begin
        got.push_back(bus_a.dec_instr_o);
        if (first_c < 0) first_c = c;
        last_c = c;
      end
      step(idx < 4, (idx < 4) ? ws[idx] : 32'h0, 32'h200 + idx * 4,
           1'b0, 1'b1, c < 3, a);
      if (a) idx++;
    end
    check("order_cnt", got.size(), 4);
    for (int i = 0; i < 4; i++)
      if (i < got.size()) check("order", got[i], ws[i]);
    check("no_bubble", last_c - first_c, 3);
    drain();

    step(1'b1, 32'h00500113, 32'h300, 1'b0, 1'b1, 1'b1, dummy);
    step(1'b1, 32'h0000A183, 32'h304, 1'b0, 1'b1, 1'b1, dummy);
    step(1'b1, 32'h00208663, 32'h308, 1'b1, 1'b1, 1'b0, dummy);
    check("flush_valid", bus_a.dec_valid_o, 0);
    check("flush_ready", bus_a.instr_ready_o, 1);
    drain();

    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 3) != 0, rand_instr(), $urandom(),
           $urandom_range(0, 19) == 0, $urandom_range(0, 3) != 0,
           $urandom_range(0, 4) == 0, dummy);
    drain();

    step(1'b1, 32'h00500113, 32'h400, 1'b0, 1'b1, 1'b1, dummy);
    step(1'b1, 32'h023100B3, 32'h404, 1'b0, 1'b1, 1'b1, dummy);
    check("full_ready", bus_a.instr_ready_o, 0);
    #3;
    rst = 1'b1; vld = 1'b0;
    #1;
    check("rst_valid", bus_a.dec_valid_o, 0);
    check("rst_ctl", ctl_a, 0);
    check("rst_instr", bus_a.dec_instr_o, 0);
    check("rst_ready", bus_a.instr_ready_o, 1);
    q.delete();
    #2;
    rst = 1'b0;
    @(posedge clk); #1;
    drain();
    step(1'b1, 32'h003100B3, 32'h500, 1'b0, 1'b1, 1'b0, dummy);
    drain();

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
